// File: rtl/rob_id_allocator.sv
// rob_id_allocator: issue-side ID allocator for the reorder buffer.
// Grants IDs to decode in program order, retires them in order on commit,
// and drops everything in flight on an exception flush. Occupancy is kept
// in an explicit counter so the pointers may wrap freely modulo 2^ID_W.
module rob_id_allocator #(
  parameter int NUM_ENTRIES = 8,
  parameter int ID_W        = 4,
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             decode_req_valid,
  output logic             decode_req_ready,
  output logic             alloc_valid,
  output logic [ID_W-1:0]  alloc_id,
  input  logic             commit_valid,
  input  logic [ID_W-1:0]  commit_id,
  input  logic             flush,
  output logic             rob_full,
  output logic             rob_empty,
  output logic [CNT_W-1:0] rob_count,
  output logic [ID_W-1:0]  rob_oldest,
  output logic             commit_error
);

  // Parameter sanity: the ID space must be at least twice the buffer so a
  // flushed ID cannot be re-granted while a stale copy might still be seen.
  if (NUM_ENTRIES < 2 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0 ||
      (1 << ID_W) < 2 * NUM_ENTRIES) begin : g_param_check
    $error("rob_id_allocator: illegal NUM_ENTRIES/ID_W combination");
  end

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

  logic [ID_W-1:0]  tail;
  logic [ID_W-1:0]  head;
  logic [CNT_W-1:0] count;
  logic             error_flag;
  logic             legal_commit;
  logic             illegal_commit;

  // Status decode and zero-latency grant; flush blocks any grant this cycle.
  always_comb begin
    rob_full         = (count == FULL_CNT);
    rob_empty        = (count == '0);
    decode_req_ready = ~rob_full & ~flush;
    alloc_valid      = decode_req_valid & decode_req_ready;
    alloc_id         = tail;
    rob_count        = count;
    rob_oldest       = head;
    commit_error     = error_flag;
    // A commit during flush is discarded outright, legal or not.
    legal_commit     = commit_valid & ~flush & ~rob_empty & (commit_id == head);
    illegal_commit   = commit_valid & ~flush & (rob_empty | (commit_id != head));
  end

  // Pointer, occupancy and sticky error state; flush outranks alloc/commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tail       <= '0;
      head       <= '0;
      count      <= '0;
      error_flag <= 1'b0;
    end else if (flush) begin
      // tail keeps counting forward so flushed IDs are not reused soon.
      head  <= tail;
      count <= '0;
    end else begin
      if (alloc_valid) begin
        tail <= tail + ID_W'(1);
      end
      if (legal_commit) begin
        head <= head + ID_W'(1);
      end
      if (alloc_valid && !legal_commit) begin
        count <= count + CNT_W'(1);
      end else if (!alloc_valid && legal_commit) begin
        count <= count - CNT_W'(1);
      end
      if (illegal_commit) begin
        error_flag <= 1'b1;
      end
    end
  end

  // Pointer distance must always equal the occupancy counter.
  always @(posedge clock) begin
    if (!reset) begin
      assert ((tail - head) == ID_W'(count));
    end
  end

endmodule

// File: tb/tb_rob_id_allocator.sv
// tb_rob_id_allocator: randomized bench with a queue-based reference model
// plus directed scenarios with literal expectations.
module tb_rob_id_allocator;

  localparam int N     = 8;
  localparam int IW    = 4;
  localparam int CW    = $clog2(N + 1);
  localparam int IDMOD = 1 << IW;

  logic          clock;
  logic          reset;
  logic          decode_req_valid;
  logic          decode_req_ready;
  logic          alloc_valid;
  logic [IW-1:0] alloc_id;
  logic          commit_valid;
  logic [IW-1:0] commit_id;
  logic          flush;
  logic          rob_full;
  logic          rob_empty;
  logic [CW-1:0] rob_count;
  logic [IW-1:0] rob_oldest;
  logic          commit_error;

  rob_id_allocator #(.NUM_ENTRIES(N), .ID_W(IW), .CNT_W(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .decode_req_valid (decode_req_valid),
    .decode_req_ready (decode_req_ready),
    .alloc_valid      (alloc_valid),
    .alloc_id         (alloc_id),
    .commit_valid     (commit_valid),
    .commit_id        (commit_id),
    .flush            (flush),
    .rob_full         (rob_full),
    .rob_empty        (rob_empty),
    .rob_count        (rob_count),
    .rob_oldest       (rob_oldest),
    .commit_error     (commit_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of in-flight IDs, next ID to grant, sticky error.
  int q[$];
  int nid  = 0;
  bit merr = 1'b0;

  // Values sampled at the last negedge, for directed literal checks.
  logic          s_av, s_ready, s_full, s_empty, s_err;
  logic [IW-1:0] s_aid, s_old;
  logic [CW-1:0] s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: check every cycle against the model, then advance it.
  int  m_sz;
  bit  e_ready, e_av, legal;
  int  e_old;
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      nid  = 0;
      merr = 1'b0;
    end
    m_sz    = q.size();
    e_ready = (m_sz != N) && !flush;
    e_av    = decode_req_valid && e_ready;
    e_old   = (m_sz > 0) ? q[0] : nid;
    chk("rob_full",  32'(rob_full),         32'(m_sz == N));
    chk("rob_empty", 32'(rob_empty),        32'(m_sz == 0));
    chk("rob_count", 32'(rob_count),        32'(m_sz));
    chk("rob_oldest", 32'(rob_oldest),      32'(e_old));
    chk("ready",     32'(decode_req_ready), 32'(e_ready));
    chk("alloc_valid", 32'(alloc_valid),    32'(e_av));
    chk("alloc_id",  32'(alloc_id),         32'(nid));
    chk("commit_error", 32'(commit_error),  32'(merr));
    if (!reset) begin
      if (flush) begin
        q.delete();
      end else begin
        legal = commit_valid && (m_sz > 0) && (int'(commit_id) == q[0]);
        if (commit_valid && !legal) merr = 1'b1;
        if (legal) void'(q.pop_front());
        if (e_av) begin
          q.push_back(nid);
          nid = (nid + 1) % IDMOD;
        end
      end
    end
  end

  // One cycle: drive just after posedge, sample at negedge, return after next posedge.
  task automatic step(input logic req, input logic cv, input logic [IW-1:0] cid, input logic fl);
    decode_req_valid = req;
    commit_valid     = cv;
    commit_id        = cid;
    flush            = fl;
    @(negedge clock);
    s_av = alloc_valid; s_aid = alloc_id; s_ready = decode_req_ready;
    s_full = rob_full; s_empty = rob_empty; s_cnt = rob_count;
    s_old = rob_oldest; s_err = commit_error;
    @(posedge clock);
    #1;
  endtask

  // Reset asserted between edges; the negedge sample shows it took effect asynchronously.
  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int r;
  logic rq, cvv, fl;
  logic [IW-1:0] cidv;

  initial begin
    reset = 1'b1;
    decode_req_valid = 1'b0;
    commit_valid = 1'b0;
    commit_id = '0;
    flush = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_count", 32'(s_cnt), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_aid",   32'(s_aid), 32'd0);

    // Fill: IDs 0..7 then full
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      chk("fill_aid", 32'(s_aid), 32'(i));
      chk("fill_av",  32'(s_av), 32'd1);
    end
    step(1'b1, 1'b0, '0, 1'b0);
    chk("full_flag",  32'(s_full), 32'd1);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_av",    32'(s_av), 32'd0);
    chk("full_count", 32'(s_cnt), 32'd8);

    // Commit while full: no same-cycle grant, then ID 8
    step(1'b1, 1'b1, 4'd0, 1'b0);
    chk("cf_av", 32'(s_av), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("cf_count", 32'(s_cnt), 32'd7);
    chk("cf_old",   32'(s_old), 32'd1);
    chk("cf_ready", 32'(s_ready), 32'd1);
    chk("cf_aid",   32'(s_aid), 32'd8);

    // Simultaneous alloc and commit at count 3
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 1'b0);
    chk("sim_aid", 32'(s_aid), 32'd3);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("sim_count", 32'(s_cnt), 32'd3);
    chk("sim_old",   32'(s_old), 32'd1);

    // Flush with IDs 4..6 in flight and a concurrent commit
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, IW'(i), 1'b0);
    step(1'b0, 1'b1, 4'd4, 1'b1);
    chk("fl_ready", 32'(s_ready), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("fl_count", 32'(s_cnt), 32'd0);
    chk("fl_empty", 32'(s_empty), 32'd1);
    chk("fl_old",   32'(s_old), 32'd7);
    chk("fl_aid",   32'(s_aid), 32'd7);
    chk("fl_err",   32'(s_err), 32'd0);

    // 20 alloc/commit pairs: IDs wrap 15 -> 0
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i > 0, IW'((i + IDMOD - 1) % IDMOD), 1'b0);
      chk("wrap_aid", 32'(s_aid), 32'(i % IDMOD));
    end
    step(1'b0, 1'b0, '0, 1'b0);
    chk("wrap_err", 32'(s_err), 32'd0);

    // Illegal commits: empty, then wrong ID; flag is sticky
    do_reset();
    step(1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("ill1_err",   32'(s_err), 32'd1);
    chk("ill1_count", 32'(s_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("ill2_err",   32'(s_err), 32'd1);
    chk("ill2_count", 32'(s_cnt), 32'd1);
    chk("ill2_old",   32'(s_old), 32'd2);
    do_reset();
    chk("ill_clr", 32'(s_err), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      rq   = $urandom_range(0, 99) < 70;
      fl   = $urandom_range(0, 99) < 4;
      cvv  = (q.size() > 0) && ($urandom_range(0, 99) < 55);
      cidv = cvv ? IW'(q[0]) : '0;
      if ($urandom_range(0, 299) == 0) begin
        cvv  = 1'b1;
        cidv = IW'($urandom_range(0, IDMOD - 1));
      end
      step(rq, cvv, cidv, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
